pipelined_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit: successor to the ripple-carry n-bit adder.

---
 rtl/pipelined_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_adder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the N-bit carry chain is cut into STAGES equal chunks,
// one chunk per register stage, with a valid/ready handshake and a synchronous flush.
module pipelined_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int W = N / STAGES;

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_param_chk
    $error("pipelined_adder: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  function automatic logic [W:0] chunk_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  logic              adv;
  logic [N-1:0]      beff;
  logic              cin_eff;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      a_d   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      b_d   [STAGES];
  logic [N-1:0]      sum_q [STAGES];
  logic [N-1:0]      sum_d [STAGES];

  logic [N-1:0]      a_src, b_src, sum_src;
  logic              c_src, v_src;
  logic [W:0]        part;

  always_comb begin
    beff    = sub ? ~b : b;
    cin_eff = sub ? ~c_in : c_in;
    // bubbles in the last stage never block, so the whole pipe moves when it is empty there
    adv     = out_ready || !v_q[STAGES-1];
  end

  // Stage s: add chunk s with the carry from stage s-1, pass operands and finished chunks on.
  always_comb begin
    a_src   = '0;
    b_src   = '0;
    sum_src = '0;
    c_src   = 1'b0;
    v_src   = 1'b0;
    part    = '0;
    v_d     = v_q;
    carry_d = carry_q;
    for (int s = 0; s < STAGES; s++) begin
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
      sum_d[s] = sum_q[s];
    end
    for (int s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        a_src   = a;
        b_src   = beff;
        sum_src = '0;
        c_src   = cin_eff;
        v_src   = in_valid;
      end else begin
        a_src   = a_q[s-1];
        b_src   = b_q[s-1];
        sum_src = sum_q[s-1];
        c_src   = carry_q[s-1];
        v_src   = v_q[s-1];
      end
      part = chunk_add(a_src[s*W +: W], b_src[s*W +: W], c_src);
      if (adv) begin
        a_d[s]              = a_src;
        b_d[s]              = b_src;
        sum_d[s]            = sum_src;
        sum_d[s][s*W +: W]  = part[W-1:0];
        carry_d[s]          = part[W];
        v_d[s]              = v_src;
      end
      // flush wins over advance and also drops a beat offered in the same cycle
      if (clr) v_d[s] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      carry_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
    end else begin
      v_q     <= v_d;
      carry_q <= carry_d;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
      end
    end
  end

  always_comb begin
    in_ready  = adv;
    out_valid = v_q[STAGES-1];
    sum       = sum_q[STAGES-1];
    c_out     = carry_q[STAGES-1];
    ovf       = (a_q[STAGES-1][N-1] == b_q[STAGES-1][N-1]) &&
                (sum_q[STAGES-1][N-1] != a_q[STAGES-1][N-1]);
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four configurations share one stimulus stream, each with its
// own arithmetic reference model and in-order scoreboard; DUT 0 (N=8, STAGES=4) gets directed checks.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        c_in;
  logic        sub;

  int checks;
  int failures;
  int acc_cnt [4];
  int pend    [4];
  bit lat_exact;

  typedef struct {
    logic [33:0] exp;
    int          t;
  } ent_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, no carry-chain structure.
  function automatic logic [33:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sb);
    longint m, half, ua, ub, sa, sbv, t, sr;
    int     ci;
    logic   co, of;
    m    = longint'(1) << n;
    half = m >> 1;
    ci   = cin ? 1 : 0;
    ua   = longint'({32'd0, a}) & (m - 1);
    ub   = longint'({32'd0, b}) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    if (!sb) begin
      t  = ua + ub + ci;
      co = (t >= m);
      sr = sa + sbv + ci;
    end else begin
      t  = ua - ub - ci;
      co = (ua >= ub + ci);
      sr = sa - sbv - ci;
    end
    of = (sr >= half) || (sr < -half);
    t  = t & (m - 1);
    return {of, co, t[31:0]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NN = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 16 : 12;
    localparam int SG = (g == 0) ? 4 : (g == 1) ? 4  : (g == 2) ? 1  : 3;
    logic [NN-1:0] s;
    logic          ir, ov, co, of;

    pipelined_adder #(.N(NN), .STAGES(SG)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (ir),
      .a        (a_in[NN-1:0]),
      .b        (b_in[NN-1:0]),
      .c_in     (c_in),
      .sub      (sub),
      .out_valid(ov),
      .out_ready(out_ready),
      .sum      (s),
      .c_out    (co),
      .ovf      (of)
    );

    initial begin
      ent_t q[$];
      ent_t e;
      int   t;
      t = 0;
      forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
          q.delete();
          pend[g] = 0;
        end else begin
          t++;
          if (ov && out_ready) begin
            if (q.size() == 0) begin
              check($sformatf("dut%0d_unexpected_out", g), 64'(ov), 64'd0);
            end else begin
              e = q.pop_front();
              check($sformatf("dut%0d_result", g), 64'({of, co, 32'(s)}), 64'(e.exp));
              if (lat_exact) check($sformatf("dut%0d_latency", g), 64'(t - e.t), 64'(SG));
            end
          end
          if (in_valid && ir && !clr) begin
            q.push_back('{model(NN, a_in, b_in, c_in, sub), t});
            acc_cnt[g]++;
          end
          if (clr) q.delete();
          pend[g] = q.size();
        end
      end
    end
  end

  logic [7:0] sum0;
  logic       ov0, co0, of0, ir0;
  assign sum0 = g_dut[0].s;
  assign ov0  = g_dut[0].ov;
  assign co0  = g_dut[0].co;
  assign of0  = g_dut[0].of;
  assign ir0  = g_dut[0].ir;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          input logic [7:0] es, input logic ec, input logic eo);
    in_valid = 1'b1; a_in = a; b_in = b; c_in = ci; sub = sb; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    check({tag, "_early"}, 64'(ov0), 64'd0);
    cyc();
    check(tag, 64'({ov0, co0, of0, sum0}), 64'({1'b1, ec, eo, es}));
    cyc();
  endtask

  initial begin
    logic [7:0] got [8];
    int         n, first, last, i, cnt, b1, b2, b3;
    bit         prev_stall;
    logic [7:0] prev_sum;

    checks = 0; failures = 0; lat_exact = 1'b0;
    for (int k = 0; k < 4; k++) begin acc_cnt[k] = 0; pend[k] = 0; end
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; c_in = 1'b0; sub = 1'b0;

    // reset state
    cyc(); cyc();
    check("reset_outputs", 64'({ov0, co0, of0, sum0}), 64'd0);
    #2 rst = 1'b0;
    cyc();
    check("reset_in_ready", 64'(ir0), 64'd1);
    check("reset_out_valid", 64'(ov0), 64'd0);

    // single beats with exact latency
    lat_exact = 1'b1;
    one_beat("add_wrap",   32'hFF, 32'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    one_beat("add_ovf",    32'h7F, 32'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    one_beat("sub_borrow", 32'h05, 32'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    one_beat("sub_ovf",    32'h80, 32'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    one_beat("add_cin",    32'h0F, 32'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    one_beat("sub_bin",    32'h10, 32'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);

    // back-to-back stream
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 8); a_in = 32'(c); b_in = 32'(3 * c); c_in = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      #1;
      if (ov0) begin
        if (n < 8) got[n] = sum0;
        n++;
        if (first < 0) first = c;
        last = c;
      end
      cyc();
    end
    check("stream_count", 64'(n), 64'd8);
    check("stream_first", 64'(first), 64'd4);
    check("stream_contig", 64'(last - first), 64'd7);
    for (int k = 0; k < 8; k++) check($sformatf("stream_sum%0d", k), 64'(got[k]), 64'(4 * k));
    lat_exact = 1'b0;

    // stream with backpressure in cycles 6..9
    n = 0; i = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int c = 0; c < 25; c++) begin
      in_valid = (i < 8); a_in = 32'(i); b_in = 32'(3 * i); c_in = 1'b0; sub = 1'b0;
      out_ready = !((c >= 6) && (c <= 9));
      #1;
      check($sformatf("bp_in_ready_c%0d", c), 64'(ir0), 64'(!((c >= 6) && (c <= 9))));
      if (prev_stall) check($sformatf("bp_hold_c%0d", c), 64'({ov0, sum0}), 64'({1'b1, prev_sum}));
      if (ov0 && out_ready) begin
        if (n < 8) got[n] = sum0;
        n++;
      end
      prev_stall = ov0 && !out_ready;
      prev_sum   = sum0;
      if (in_valid && ir0) i++;
      cyc();
    end
    check("bp_count", 64'(n), 64'd8);
    for (int k = 0; k < 8; k++) check($sformatf("bp_sum%0d", k), 64'(got[k]), 64'(4 * k));

    // asynchronous reset with beats in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a_in = 32'h7F; b_in = 32'h01; c_in = 1'b0; sub = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc();
    check("rst_pre_out", 64'({ov0, of0, sum0}), 64'({1'b1, 1'b1, 8'h80}));
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", 64'({ov0, co0, of0, sum0}), 64'd0);
    check("rst_async_ready", 64'(ir0), 64'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    out_ready = 1'b1;
    check("rst_ready_after", 64'(ir0), 64'd1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (ov0) cnt++;
      cyc();
    end
    check("rst_no_stale", 64'(cnt), 64'd0);

    // flush with two beats in flight plus one offered alongside clr
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a_in = 32'h21; b_in = 32'h12; c_in = 1'b0; sub = 1'b0;
      cyc();
    end
    clr = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("clr_immediate", 64'(ov0), 64'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (ov0) cnt++;
      cyc();
    end
    check("clr_no_output", 64'(cnt), 64'd0);

    // randomized traffic against the reference model
    b1 = acc_cnt[1]; b2 = acc_cnt[2]; b3 = acc_cnt[3];
    cnt = 0;
    while (((acc_cnt[1] - b1) < 10000 || (acc_cnt[2] - b2) < 10000 || (acc_cnt[3] - b3) < 10000)
           && cnt < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       a_in = 32'h0;
        1:       a_in = 32'hFFFF_FFFF;
        2:       a_in = 32'h8000_0800;
        default: a_in = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b_in = 32'h0;
        1:       b_in = 32'hFFFF_FFFF;
        2:       b_in = 32'h7FFF_F7FF;
        default: b_in = $urandom;
      endcase
      c_in = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      cyc();
      cnt++;
    end
    check("rand_budget", 64'(cnt < 40000), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) cyc();
    for (int k = 0; k < 4; k++) check($sformatf("drain_dut%0d", k), 64'(pend[k]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
